// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer: phase codes,
// lamp encodings and default dwell durations (in ticks).
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED_B = 3'd0,
    NS_GRN   = 3'd1,
    NS_YEL   = 3'd2,
    ALLRED_A = 3'd3,
    EW_GRN   = 3'd4,
    EW_YEL   = 3'd5,
    PED_WALK = 3'd6
  } phase_e;

  // Lamp encodings, {red,yellow,green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int NS_GRN_DEF = 15;
  localparam int EW_GRN_DEF = 10;
  localparam int YEL_DEF    = 2;
  localparam int ALLRED_DEF = 1;
  localparam int WALK_DEF   = 6;
  localparam int CNT_W_DEF  = 5;

  // {ns_light, ew_light} shown while in phase p; anything else is all-red.
  function automatic logic [5:0] lights(phase_e p);
    case (p)
      NS_GRN:  return {GRN, RED};
      NS_YEL:  return {YEL, RED};
      EW_GRN:  return {RED, GRN};
      EW_YEL:  return {RED, YEL};
      default: return {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter: loads (duration-1) on phase entry, decrements on each tick
// until it reaches zero. done flags the zero count (the transition tick).
module phase_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; counting stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= CNT_W'(RST_VAL);
    else if (load)                 cnt_q <= load_val;
    else if (tick && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign count = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/intersection_sequencer.sv
// Two-approach traffic light sequencer with all-red clearance and an
// optional pedestrian walk phase (enabled by INTERSECTION_PED_WALK_EN).
// Lamp outputs are registered from the next state so they change together
// with phase; reset forces all-red asynchronously.
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int NS_GRN_TICKS = NS_GRN_DEF,
  parameter int EW_GRN_TICKS = EW_GRN_DEF,
  parameter int YEL_TICKS    = YEL_DEF,
  parameter int ALLRED_TICKS = ALLRED_DEF,
  parameter int WALK_TICKS   = WALK_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sensor_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] NS_LD     = CNT_W'(NS_GRN_TICKS - 1);
  localparam logic [CNT_W-1:0] EW_LD     = CNT_W'(EW_GRN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LD    = CNT_W'(YEL_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);

  phase_e           state_q, state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;
  logic [CNT_W-1:0] unused_cnt;
  logic             ped_go;
  logic [2:0]       ns_q, ew_q;

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_TICKS - 1)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .load_val(load_val),
    .count   (unused_cnt),
    .done    (done)
  );

`ifdef INTERSECTION_PED_WALK_EN
  logic ped_q, ped_d, walk_q, enter_walk;

  assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
  // A new request in the same cycle as walk entry stays latched.
  assign ped_d      = ped_req | (ped_q & ~enter_walk);
  assign ped_go     = ped_q;

  // Pending pedestrian request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ped_q <= 1'b0;
    else     ped_q <= ped_d;
  end

  // Walk lamp registered from next state, aligned with phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) walk_q <= 1'b0;
    else     walk_q <= (state_d == PED_WALK);
  end

  assign walk = walk_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_go     = 1'b0;
  assign walk       = 1'b0;
`endif

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ALLRED_B;
    else     state_q <= state_d;
  end

  // Next phase: leave on the tick that sees a zero count; NS green also
  // waits for demand. Unknown codes fall back to ALLRED_B immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALLRED_B: if (tick && done) state_d = ped_go ? PED_WALK : NS_GRN;
      NS_GRN:   if (tick && done && (sensor_ew || ped_go)) state_d = NS_YEL;
      NS_YEL:   if (tick && done) state_d = ALLRED_A;
      ALLRED_A: if (tick && done) state_d = EW_GRN;
      EW_GRN:   if (tick && done) state_d = EW_YEL;
      EW_YEL:   if (tick && done) state_d = ALLRED_B;
`ifdef INTERSECTION_PED_WALK_EN
      PED_WALK: if (tick && done) state_d = NS_GRN;
`endif
      default:  state_d = ALLRED_B;
    endcase
  end

  // Reload the dwell counter whenever the phase changes.
  always_comb begin
    load     = (state_d != state_q);
    load_val = ALLRED_LD;
    case (state_d)
      NS_GRN:         load_val = NS_LD;
      NS_YEL, EW_YEL: load_val = YEL_LD;
      EW_GRN:         load_val = EW_LD;
      PED_WALK:       load_val = WALK_LD;
      default:        load_val = ALLRED_LD;
    endcase
  end

  // Lamp registers driven from the next phase so there is no extra lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {ns_q, ew_q} <= {RED, RED};
    else     {ns_q, ew_q} <= lights(state_d);
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Randomized + directed bench for intersection_sequencer against a
// phase/elapsed-tick reference model.
module tb_intersection_sequencer;
  import traffic_pkg::*;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, sensor_ew = 1'b0, ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef INTERSECTION_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  // Reference model state: current phase, ticks spent in it, pending request.
  phase_e m_ph  = ALLRED_B;
  int     m_el  = 0;
  bit     m_ped = 1'b0;

  intersection_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sensor_ew(sensor_ew),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(phase_e p);
    case (p)
      NS_GRN:         return 15;
      NS_YEL, EW_YEL: return 2;
      EW_GRN:         return 10;
      PED_WALK:       return 6;
      default:        return 1;
    endcase
  endfunction

  function automatic phase_e succ(phase_e p, bit ped);
    case (p)
      ALLRED_B: return (PED_EN && ped) ? PED_WALK : NS_GRN;
      NS_GRN:   return NS_YEL;
      NS_YEL:   return ALLRED_A;
      ALLRED_A: return EW_GRN;
      EW_GRN:   return EW_YEL;
      EW_YEL:   return ALLRED_B;
      default:  return NS_GRN;
    endcase
  endfunction

  function automatic int exp_ns(phase_e p);
    if (p == NS_GRN) return 1;
    if (p == NS_YEL) return 2;
    return 4;
  endfunction

  function automatic int exp_ew(phase_e p);
    if (p == EW_GRN) return 1;
    if (p == EW_YEL) return 2;
    return 4;
  endfunction

  // Advance the model by one clock using the inputs the DUT sampled.
  task automatic model_step();
    phase_e nx;
    bit     go;
    if (rst) begin
      m_ph = ALLRED_B; m_el = 0; m_ped = 1'b0;
      return;
    end
    nx = m_ph;
    if (tick) begin
      go = (m_el >= dur(m_ph) - 1) && (m_ph != NS_GRN || sensor_ew || m_ped);
      if (go) begin nx = succ(m_ph, m_ped); m_el = 0; end
      else m_el++;
    end
    m_ped = PED_EN && (ped_req || (m_ped && !(nx == PED_WALK && m_ph != PED_WALK)));
    m_ph  = nx;
  endtask

  task automatic check_all();
    chk("phase",    phase,    m_ph);
    chk("ns_light", ns_light, exp_ns(m_ph));
    chk("ew_light", ew_light, exp_ew(m_ph));
    chk("walk",     walk,     (m_ph == PED_WALK));
    chk("conflict", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
    chk("ns_onehot", $onehot(ns_light), 1);
    chk("ew_onehot", $onehot(ew_light), 1);
  endtask

  // Called at a negedge: drive inputs, clock once, update model, check.
  task automatic step(input bit t, input bit s, input bit p);
    tick = t; sensor_ew = s; ped_req = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input phase_e target, input bit s, input int budget);
    int n = 0;
    while (m_ph != target && n < budget) begin
      step(1'b1, s, 1'b0);
      n++;
    end
    chk("reach_phase", phase, target);
  endtask

  initial begin
    phase_e exp_q[$];

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_phase", phase, ALLRED_B);
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);
    chk("rst_walk", walk, 0);
    @(negedge clk);
    check_all();
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;

    // First tick after release reaches NS green, which then holds.
    step(1, 0, 0);
    chk("first_tick_nsgrn", phase, NS_GRN);
    repeat (100) begin
      step(1, 0, 0);
      chk("ns_hold", phase, NS_GRN);
    end

    // Demand from EW: full cycle with explicit durations.
    exp_q = {NS_YEL, NS_YEL, ALLRED_A};
    repeat (10) exp_q.push_back(EW_GRN);
    exp_q.push_back(EW_YEL); exp_q.push_back(EW_YEL);
    exp_q.push_back(ALLRED_B); exp_q.push_back(NS_GRN);
    foreach (exp_q[i]) begin
      step(1, 1, 0);
      chk("ew_seq", phase, exp_q[i]);
    end

    // Pedestrian pulse during EW green.
    run_until(EW_GRN, 1'b1, 100);
    step(1, 1, 1);
    run_until(ALLRED_B, 1'b0, 100);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      chk("ped_phase", phase, PED_EN ? PED_WALK : NS_GRN);
      chk("ped_walk", walk, PED_EN);
    end
    step(1, 0, 0);
    chk("after_walk", phase, NS_GRN);
    repeat (20) step(1, 0, 0);
    chk("ped_cleared", phase, NS_GRN);

    // Asynchronous reset between clock edges in EW green.
    run_until(EW_GRN, 1'b1, 100);
    step(1, 1, 0);
    step(1, 1, 0);
    tick = 1'b1;
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1;
    chk("async_phase", phase, ALLRED_B);
    chk("async_ns", ns_light, 3'b100);
    chk("async_ew", ew_light, 3'b100);
    chk("async_walk", walk, 0);
    model_step();
    @(negedge clk);
    check_all();
    step(1, 1, 0);
    step(1, 1, 0);
    rst = 1'b0;
    step(1, 0, 0);
    chk("restart_nsgrn", phase, NS_GRN);
    repeat (20) begin
      step(1, 0, 0);
      chk("restart_hold", phase, NS_GRN);
    end

    // Tick starvation freezes EW yellow.
    run_until(EW_YEL, 1'b1, 200);
    repeat (50) begin
      step(0, 1, 0);
      chk("freeze", phase, EW_YEL);
    end
    step(1, 1, 0);
    chk("unfreeze_1", phase, EW_YEL);
    step(1, 1, 0);
    chk("unfreeze_2", phase, ALLRED_B);

    // Random traffic.
    begin
      bit s = 1'b0;
      repeat (3000) begin
        if ($urandom_range(0, 19) == 0) s = ~s;
        if ($urandom_range(0, 599) == 0) rst = 1'b1;
        step($urandom_range(0, 3) != 0, s, $urandom_range(0, 39) == 0);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_sequencer.md
INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
- REQ-001 SHALL have parameter NS_GRN_TICKS, default 15, minimum north-south green in ticks.
- REQ-002 SHALL have parameter EW_GRN_TICKS, default 10, fixed east-west green in ticks.
- REQ-003 SHALL have parameter YEL_TICKS, default 2, yellow duration per approach.
- REQ-004 SHALL have parameter ALLRED_TICKS, default 1, all-red clearance duration.
- REQ-005 SHALL have parameter WALK_TICKS, default 6, pedestrian walk duration.
- REQ-006 SHALL have parameter CNT_W, default 5, dwell counter width; all durations are in 1..2^CNT_W.
- REQ-007 clk  input  1  single clock; all state updates on posedge.
- REQ-008 rst  input  1  reset, asynchronous, active-high.
- REQ-009 tick  input  1  one-cycle timing strobe; dwell counter advances only when tick=1.
- REQ-010 sensor_ew  input  1  level; vehicle waiting on the east-west approach.
- REQ-011 ped_req  input  1  pedestrian push-button; a single-cycle pulse is sufficient.
- REQ-012 ns_light  output  3  {red,yellow,green} north-south, registered, one-hot.
- REQ-013 ew_light  output  3  {red,yellow,green} east-west, registered, one-hot.
- REQ-014 walk  output  1  pedestrian walk lamp, registered.
- REQ-015 phase  output  3  current state code, from package enum.

Function
- REQ-016 SHALL implement states ALLRED_B, NS_GRN, NS_YEL, ALLRED_A, EW_GRN, EW_YEL, PED_WALK.
- REQ-017 On entry to a state, counter SHALL load that state's duration minus 1; every tick with count>0 decrements it.
- REQ-018 Tick with count==0 SHALL be the transition cycle, so a state lasts exactly its duration in ticks.
- REQ-019 ALLRED_B→NS_GRN, NS_YEL→ALLRED_A, ALLRED_A→EW_GRN, EW_GRN→EW_YEL, EW_YEL→ALLRED_B, PED_WALK→NS_GRN.
- REQ-020 NS_GRN SHALL hold at count==0 until sensor_ew=1 or ped_pending=1, then leave on the next tick: →NS_YEL.
- REQ-021 ALLRED_B SHALL go to PED_WALK instead of NS_GRN when ped_pending=1.
- REQ-022 ped_pending SHALL be set by ped_req in any cycle and cleared on entry to PED_WALK; set wins over a same-cycle clear.
- REQ-023 Lights per state: NS_GRN ns=001/ew=100; NS_YEL ns=010/ew=100; EW_GRN ns=100/ew=001; EW_YEL ns=100/ew=010; ALLRED_x and PED_WALK both 100.
- REQ-024 walk=1 only in PED_WALK.
- REQ-025 ns_light and ew_light SHALL never both be non-red in the same cycle.
- REQ-026 Outputs SHALL change in the same cycle phase changes; there is no extra latency stage.
- REQ-027 An illegal state encoding SHALL recover to ALLRED_B with counter ALLRED_TICKS-1.

Reset
- REQ-028 While rst=1, state SHALL be ALLRED_B, counter ALLRED_TICKS-1, and ped_pending=0.
- REQ-029 While rst=1, ns_light=100, ew_light=100, walk=0, and phase=ALLRED_B.
- REQ-030 Reset asserted mid-phase SHALL force REQ-028/029 immediately, without waiting for clk.
- REQ-031 After reset release, operation SHALL resume from ALLRED_B on the next tick.

Configuration
- REQ-032 Macro INTERSECTION_PED_WALK_EN defined: pedestrian logic per REQ-021/022/024.
- REQ-033 Macro absent: ped_req is ignored, ped_pending and PED_WALK are removed, walk is tied 0, and ALLRED_B always goes to NS_GRN.

Structure
- REQ-034 Package traffic_pkg SHALL hold the phase enum, the light encodings (RED=100, YEL=010, GRN=001) and the default durations.
- REQ-035 Sub-module phase_timer (load, load_val, tick → count, done) SHALL implement the dwell counter.

Verification
- REQ-036 Defaults, tick every cycle, release rst, sensor_ew=0: after 1 tick phase=NS_GRN; hold NS_GRN for 100 ticks.
- REQ-037 Raise sensor_ew at tick 20 and keep it high: NS_YEL for 2 ticks, ALLRED_A 1, EW_GRN 10, EW_YEL 2, ALLRED_B 1, then NS_GRN again.
- REQ-038 With the macro defined, pulse ped_req 1 cycle during EW_GRN: after ALLRED_B, walk=1 for 6 ticks, both lights red, then NS_GRN and ped_pending=0.
- REQ-039 Assert rst mid-EW_GRN, between clk edges: outputs go all-red, walk=0 asynchronously; after release, sequence restarts per REQ-036.
- REQ-040 tick held 0 for 50 cycles in EW_YEL: state and counter are frozen.
- REQ-041 In every scenario, assert REQ-025 and one-hot lights on every cycle.
